// File: rtl/mask_share_gen_pkg.sv
// Shared definitions for the Boolean masking share generator: LFSR constants,
// FSM state encoding and the single-step LFSR function used by RTL and bench.
package mask_share_gen_pkg;

    localparam logic [15:0] LFSR_SEED_DEFAULT = 16'hACE1;
    localparam int          WARMUP_CYCLES_DEFAULT = 16;

    // Fibonacci taps for x^16 + x^14 + x^13 + x^11 + 1 (bit positions of the register)
    localparam int TAP_A = 15;
    localparam int TAP_B = 13;
    localparam int TAP_C = 12;
    localparam int TAP_D = 10;

    typedef enum logic {
        WARMUP = 1'b0,
        RUN    = 1'b1
    } state_e;

    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return {s[14:0], s[TAP_A] ^ s[TAP_B] ^ s[TAP_C] ^ s[TAP_D]};
    endfunction

endpackage

// File: rtl/mask_share_gen_if.sv
// Operand input handshake and masked-share output handshake of mask_share_gen.
interface mask_share_if;

    logic in_valid;
    logic in_ready;
    logic A;
    logic B;

    logic out_valid;
    logic out_ready;
    logic A0;
    logic A1;
    logic B0;
    logic B1;
    logic r0;
    logic r1;
    logic r2;

    // slave: the share generator itself; master: the upstream/downstream environment
    modport slave (
        input  in_valid, A, B, out_ready,
        output in_ready, out_valid, A0, A1, B0, B1, r0, r1, r2
    );

    modport master (
        output in_valid, A, B, out_ready,
        input  in_ready, out_valid, A0, A1, B0, B1, r0, r1, r2
    );

endinterface

// File: rtl/mask_lfsr16.sv
// 16-bit Fibonacci LFSR with seed load (zero seed replaced by the default),
// single-step and five-step advance controls.
module mask_lfsr16 #(
    parameter logic [15:0] SEED_DEFAULT = mask_share_gen_pkg::LFSR_SEED_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [15:0] load_value,
    input  logic        step1,
    input  logic        step5,
    output logic [15:0] state
);
    import mask_share_gen_pkg::*;

    logic [15:0] state_q;
    logic [15:0] state_d;
    logic [15:0] five_steps;

    always_comb begin
        five_steps = state_q;
        for (int i = 0; i < 5; i++) begin
            five_steps = lfsr_step(five_steps);
        end
    end

    // Load wins over stepping; a zero seed would lock the register, so it is substituted
    always_comb begin
        state_d = state_q;
        if (load) begin
            state_d = (load_value == 16'h0000) ? SEED_DEFAULT : load_value;
        end else if (step5) begin
            state_d = five_steps;
        end else if (step1) begin
            state_d = lfsr_step(state_q);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= SEED_DEFAULT;
        end else begin
            state_q <= state_d;
        end
    end

    assign state = state_q;

endmodule

// File: rtl/mask_share_gen.sv
// Splits operand bits A, B into two Boolean shares each and supplies fresh
// randomness r0..r2 for a downstream masked gate, one result per cycle.
module mask_share_gen #(
    parameter logic [15:0] SEED_DEFAULT  = mask_share_gen_pkg::LFSR_SEED_DEFAULT,
    parameter int          WARMUP_CYCLES = mask_share_gen_pkg::WARMUP_CYCLES_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        seed_valid,
    input  logic [15:0] seed,
    output logic        busy,
    mask_share_if.slave bus
);
    import mask_share_gen_pkg::*;

    localparam logic [15:0] WARMUP_LAST = 16'(WARMUP_CYCLES - 1);

    state_e      state_q;
    state_e      state_d;
    logic [15:0] count_q;
    logic [15:0] count_d;
    logic        out_valid_q;
    logic        out_valid_d;
    logic [6:0]  data_q;
    logic [6:0]  data_d;

    logic [15:0] lfsr;
    logic        lfsr_load;
    logic        lfsr_step1;
    logic        lfsr_step5;
    logic        in_ready;
    logic        accept;

    mask_lfsr16 #(
        .SEED_DEFAULT(SEED_DEFAULT)
    ) u_lfsr (
        .clk       (clk),
        .rst       (rst),
        .load      (lfsr_load),
        .load_value(seed),
        .step1     (lfsr_step1),
        .step5     (lfsr_step5),
        .state     (lfsr)
    );

    // A reseed overrides everything, dropping any pending output and blocking accept
    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        out_valid_d = out_valid_q;
        data_d      = data_q;
        lfsr_load   = 1'b0;
        lfsr_step1  = 1'b0;
        lfsr_step5  = 1'b0;
        in_ready    = 1'b0;
        accept      = 1'b0;

        if (seed_valid) begin
            lfsr_load   = 1'b1;
            count_d     = 16'h0000;
            state_d     = WARMUP;
            out_valid_d = 1'b0;
        end else begin
            case (state_q)
                WARMUP: begin
                    lfsr_step1 = 1'b1;
                    if (count_q == WARMUP_LAST) begin
                        state_d = RUN;
                        count_d = 16'h0000;
                    end else begin
                        count_d = count_q + 16'h0001;
                    end
                end
                RUN: begin
                    in_ready = !out_valid_q || bus.out_ready;
                    accept   = in_ready && bus.in_valid;
                    if (accept) begin
                        lfsr_step5  = 1'b1;
                        out_valid_d = 1'b1;
                        data_d      = {bus.A ^ lfsr[0], lfsr[0],
                                       bus.B ^ lfsr[1], lfsr[1],
                                       lfsr[2], lfsr[3], lfsr[4]};
                    end else if (bus.out_ready) begin
                        out_valid_d = 1'b0;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= WARMUP;
            count_q     <= 16'h0000;
            out_valid_q <= 1'b0;
            data_q      <= 7'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            out_valid_q <= out_valid_d;
            data_q      <= data_d;
        end
    end

    assign busy         = (state_q == WARMUP);
    assign bus.in_ready = in_ready;
    assign bus.out_valid = out_valid_q;
    assign {bus.A0, bus.A1, bus.B0, bus.B1, bus.r0, bus.r1, bus.r2} = data_q;

endmodule

// File: doc/mask_share_gen.md
MASK_SHARE_GEN -- requirements
Module: mask_share_gen

Interface
REQ-001 Parameter SEED_DEFAULT, 16'hACE1: LFSR value loaded at reset and substituted whenever a zero seed is supplied.
REQ-002 Parameter WARMUP_CYCLES, 16: number of single LFSR steps taken after reset or reseed before inputs are accepted.
REQ-003 The block SHALL have one clock; reset is asynchronous and active-high.
REQ-004 clk  in  1  sole clock; all state updates on rising edge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 seed_valid  in  1  one-cycle strobe that loads seed.
REQ-007 seed  in  16  new LFSR seed.
REQ-008 in_valid / in_ready  in / out  1 / 1  input handshake for unmasked operands.
REQ-009 A, B  in  1 each  unmasked operand bits.
REQ-010 out_valid / out_ready  out / in  1 / 1  output handshake toward the downstream masked-gate stage.
REQ-011 A0, A1, B0, B1  out  1 each  Boolean shares, with A0^A1 = A and B0^B1 = B.
REQ-012 r0, r1, r2  out  1 each  fresh randomness for the downstream gate.
REQ-013 busy  out  1  high while in WARMUP.

Function
REQ-014 The state machine SHALL have two states, WARMUP and RUN; reset enters WARMUP with lfsr = SEED_DEFAULT and the warmup count = 0.
REQ-015 The LFSR SHALL be a 16-bit Fibonacci register that shifts left by one bit per step, with new bit0 = b15^b13^b12^b10 (x^16+x^14+x^13+x^11+1).
REQ-016 In WARMUP, the LFSR SHALL take one step per cycle and the count SHALL increment; when the count reaches WARMUP_CYCLES-1 the next state is RUN; in_ready = 0 throughout.
REQ-017 In RUN, in_ready SHALL equal (!out_valid || out_ready) && !seed_valid.
REQ-018 On accept (in_valid && in_ready), the output register SHALL load m_a = lfsr[0], m_b = lfsr[1], A0 = A^m_a, A1 = m_a, B0 = B^m_b, B1 = m_b, r0 = lfsr[2], r1 = lfsr[3], r2 = lfsr[4]; out_valid = 1 on the next edge (latency 1 cycle).
REQ-019 On accept, the LFSR SHALL advance exactly 5 steps in one cycle; in RUN it SHALL not advance on any cycle without an accept.
REQ-020 While out_valid && !out_ready, all outputs SHALL hold stable.
REQ-021 out_valid SHALL clear when out_ready && !accept; simultaneous drain and accept SHALL keep out_valid = 1 with new data (full throughput, 1 per cycle).
REQ-022 seed_valid in any state SHALL take priority: lfsr <= (seed==0 ? SEED_DEFAULT : seed), count <= 0, state <= WARMUP, out_valid <= 0 (the pending output is dropped), and no input is accepted that cycle.
REQ-023 The LFSR SHALL never hold zero.

Reset
REQ-024 Asserting rst SHALL immediately force: state WARMUP, lfsr = SEED_DEFAULT, count 0, out_valid 0, A0 = A1 = B0 = B1 = r0 = r1 = r2 = 0, in_ready 0, busy 1.
REQ-025 Reset asserted mid-transaction SHALL discard the held output, with no partial handshake after release.

Structure
REQ-026 A shared package SHALL hold SEED_DEFAULT, the tap constants, the state enum, and a pure lfsr_step function (1 step) used both by RTL and by the bench model.
REQ-027 One sub-module, mask_lfsr16 (load, step1, step5 controls), SHALL be used; the handshake, FSM, and output register reside in mask_share_gen.

Verification
REQ-028 Reset release, idle inputs -> busy = 1 for exactly 16 cycles, then in_ready = 1; lfsr equals 16 applications of lfsr_step to 16'hACE1.
REQ-029 All four (A,B) combinations streamed with out_ready = 1 -> one output per cycle; A0^A1 = A, B0^B1 = B; A1, B1, r0..r2 match the package model.
REQ-030 out_ready held 0 for 5 cycles with out_valid = 1 -> outputs stable, in_ready = 0, LFSR unchanged; release -> the next input is accepted the same cycle.
REQ-031 seed_valid with seed = 16'h0000 while out_valid = 1 -> out_valid = 0 next cycle, lfsr = 16'hACE1, busy = 1 for 16 cycles.
REQ-032 seed_valid with seed = 16'h1234 coincident with in_valid -> input not accepted; the post-warmup first output matches the model seeded with 16'h1234.
REQ-033 rst pulsed for 1 cycle mid-stream -> all outputs 0 immediately, and behaviour is identical to REQ-028 afterward.
